// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample/volume types and constants
package audio_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int VOL_W     = 4;
    localparam int VOL_UNITY = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [VOL_W-1:0]           vol_t;

    localparam sample_t SAMPLE_MAX = 24'sh7FFFFF;
    localparam sample_t SAMPLE_MIN = 24'sh800000;

endpackage

// File: rtl/axis_pipe_reg.sv
// rtl/axis_pipe_reg.sv - one elastic register stage with ready chaining
module axis_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    input  logic         s_tlast,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    output logic         m_tlast,
    input  logic         m_tready
);

    // Load whenever the stage is empty or its content is taken this cycle.
    assign s_tready = !m_tvalid || m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
            if (s_tvalid) begin
                m_tdata <= s_tdata;
                m_tlast <= s_tlast;
            end
        end
    end

endmodule

// File: rtl/axis_volume_ctrl.sv
// rtl/axis_volume_ctrl.sv - frame-gated volume/mute gain stage with saturation and clip hold
module axis_volume_ctrl
    import audio_pkg::*;
#(
    parameter int WIDTH_P     = 24,
    parameter int VOL_W_P     = 4,
    parameter int VOL_RESET_P = VOL_UNITY,
    parameter int SHIFT_P     = 3,
    parameter int CLIP_HOLD_P = 4096
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               vol_up_i,
    input  logic               vol_down_i,
    input  logic               mute_i,
    input  logic [WIDTH_P-1:0] s_data_i,
    input  logic               s_valid_i,
    input  logic               s_last_i,
    output logic               s_ready_o,
    output logic [WIDTH_P-1:0] m_data_o,
    output logic               m_valid_o,
    output logic               m_last_o,
    input  logic               m_ready_i,
    output logic [VOL_W_P-1:0] vol_o,
    output logic               mute_o,
    output logic               clip_o
);

    localparam int PW = WIDTH_P + VOL_W_P + 1;
    localparam int CW = $clog2(CLIP_HOLD_P + 1);

    logic [VOL_W_P-1:0]   vol_pend, vol_active;
    logic                 mute_pend, mute_active, frame_busy;
    logic                 in_xfer, out_xfer, gate_load;
    logic signed [PW-1:0] data_ext, vol_ext, product, s1_data, shifted;
    logic                 s1_valid, s1_last, s1_ready;
    logic [WIDTH_P-1:0]   sat;
    logic                 sat_clip, fits;
    logic [WIDTH_P:0]     s2_data;
    logic [CW-1:0]        clip_cnt;

    assign in_xfer  = s_valid_i & s_ready_o;
    assign out_xfer = m_valid_o & m_ready_i;
    // An L sample opening a frame must not see a gain change, so L and R share one gain.
    assign gate_load = in_xfer ? s_last_i : !frame_busy;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vol_pend    <= VOL_W_P'(VOL_RESET_P);
            vol_active  <= VOL_W_P'(VOL_RESET_P);
            mute_pend   <= 1'b0;
            mute_active <= 1'b0;
            frame_busy  <= 1'b0;
        end else begin
            if (vol_up_i && !vol_down_i && vol_pend != '1)
                vol_pend <= vol_pend + VOL_W_P'(1);
            else if (vol_down_i && !vol_up_i && vol_pend != '0)
                vol_pend <= vol_pend - VOL_W_P'(1);
            if (mute_i)
                mute_pend <= !mute_pend;
            if (in_xfer)
                frame_busy <= !s_last_i;
            if (gate_load) begin
                vol_active  <= vol_pend;
                mute_active <= mute_pend;
            end
        end
    end

    assign data_ext = {{(VOL_W_P+1){s_data_i[WIDTH_P-1]}}, s_data_i};
    assign vol_ext  = {{(WIDTH_P+1){1'b0}}, vol_active};
    assign product  = mute_active ? '0 : data_ext * vol_ext;

    axis_pipe_reg #(.W(PW)) u_s1 (
        .clk      (clk_i),
        .rst      (reset_i),
        .s_tdata  (product),
        .s_tvalid (s_valid_i),
        .s_tlast  (s_last_i),
        .s_tready (s_ready_o),
        .m_tdata  (s1_data),
        .m_tvalid (s1_valid),
        .m_tlast  (s1_last),
        .m_tready (s1_ready)
    );

    // Result fits in WIDTH_P bits when every bit above the sample sign bit matches it.
    assign shifted = s1_data >>> SHIFT_P;
    assign fits    = shifted[PW-1:WIDTH_P-1] == {(PW-WIDTH_P+1){shifted[PW-1]}};

    always_comb begin
        sat      = shifted[WIDTH_P-1:0];
        sat_clip = 1'b0;
        if (!fits) begin
            sat_clip = 1'b1;
            sat      = shifted[PW-1] ? {1'b1, {(WIDTH_P-1){1'b0}}}
                                     : {1'b0, {(WIDTH_P-1){1'b1}}};
        end
    end

    axis_pipe_reg #(.W(WIDTH_P+1)) u_s2 (
        .clk      (clk_i),
        .rst      (reset_i),
        .s_tdata  ({sat_clip, sat}),
        .s_tvalid (s1_valid),
        .s_tlast  (s1_last),
        .s_tready (s1_ready),
        .m_tdata  (s2_data),
        .m_tvalid (m_valid_o),
        .m_tlast  (m_last_o),
        .m_tready (m_ready_i)
    );

    assign m_data_o = s2_data[WIDTH_P-1:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            clip_o   <= 1'b0;
            clip_cnt <= '0;
        end else if (out_xfer && s2_data[WIDTH_P]) begin
            clip_o   <= 1'b1;
            clip_cnt <= CW'(CLIP_HOLD_P - 1);
        end else if (clip_o) begin
            if (clip_cnt == '0)
                clip_o <= 1'b0;
            else
                clip_cnt <= clip_cnt - CW'(1);
        end
    end

    assign vol_o  = vol_active;
    assign mute_o = mute_active;

endmodule

// File: tb/tb_axis_volume_ctrl.sv
// tb/tb_axis_volume_ctrl.sv - scoreboard bench for axis_volume_ctrl
module tb_axis_volume_ctrl;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        vol_up = 1'b0, vol_down = 1'b0, mute_in = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [23:0] m_data;
    logic        m_valid, m_last;
    logic        m_ready = 1'b1;
    logic [3:0]  vol_o;
    logic        mute_o, clip_o;

    axis_volume_ctrl dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .vol_up_i   (vol_up),
        .vol_down_i (vol_down),
        .mute_i     (mute_in),
        .s_data_i   (s_data),
        .s_valid_i  (s_valid),
        .s_last_i   (s_last),
        .s_ready_o  (s_ready),
        .m_data_o   (m_data),
        .m_valid_o  (m_valid),
        .m_last_o   (m_last),
        .m_ready_i  (m_ready),
        .vol_o      (vol_o),
        .mute_o     (mute_o),
        .clip_o     (clip_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] data;
        logic        last;
        bit          clip;
        int          in_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0, n_total = 0;
    int   cyc = 0;
    int   pend_vol = 8, act_vol = 8;
    bit   pend_mute = 0, act_mute = 0, in_frame = 0;
    bit   chk_lat = 0, rand_mode = 0;
    bit   hold_pend = 0, prev_clip = 0;
    logic [23:0] hold_data;
    logic        hold_last;
    int   last_clip_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Reference: out = floor(sample * vol / 8), clamped to the 24-bit range.
    function automatic exp_t model(input logic [23:0] d, input logic l, input int vol, input bit mu);
        exp_t   e;
        longint x, r;
        sample_t sd;
        sd = d;
        x = mu ? 0 : longint'(sd) * vol;
        r = (x >= 0) ? x / 8 : -((-x + 7) / 8);
        e.clip = 0;
        if (r > longint'(SAMPLE_MAX)) begin r = SAMPLE_MAX; e.clip = 1; end
        if (r < longint'(SAMPLE_MIN)) begin r = SAMPLE_MIN; e.clip = 1; end
        e.data = 24'(r);
        e.last = l;
        e.in_cyc = 0;
        return e;
    endfunction

    task automatic send(input logic [23:0] d, input logic l, input bit up);
        exp_t e;
        int   n;
        bit   rd;
        e = model(d, l, act_vol, act_mute);
        s_data = d; s_last = l; s_valid = 1'b1; vol_up = up;
        if (up && pend_vol < 15) pend_vol++;
        n = 0;
        do begin
            #4 rd = s_ready;
            @(negedge clk);
            vol_up = 1'b0;
            n++;
        end while (!rd && n < 200);
        if (!rd) chk(0, "s_ready_timeout", 0, 1);
        e.in_cyc = cyc;
        sb.push_back(e);
        if (l) begin
            act_vol = pend_vol; act_mute = pend_mute; in_frame = 0;
        end else begin
            in_frame = 1;
        end
    endtask

    task automatic pulse(input bit up, input bit dn, input bit mu);
        s_valid = 1'b0;
        vol_up = up; vol_down = dn; mute_in = mu;
        @(negedge clk);
        vol_up = 1'b0; vol_down = 1'b0; mute_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (up && !dn && pend_vol < 15) pend_vol++;
        else if (dn && !up && pend_vol > 0) pend_vol--;
        if (mu) pend_mute = !pend_mute;
        if (!in_frame) begin act_vol = pend_vol; act_mute = pend_mute; end
    endtask

    task automatic drain();
        int n;
        s_valid = 1'b0;
        rand_mode = 0;
        m_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        chk(sb.size() == 0, "drain", sb.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on each output transfer; checks stall stability and clip set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (reset_i) begin
                hold_pend = 0; prev_clip = 0;
            end else begin
                if (prev_clip) chk(clip_o == 1'b1, "clip_set", clip_o, 1);
                prev_clip = 0;
                if (hold_pend)
                    chk(m_valid && m_data == hold_data && m_last == hold_last,
                        "stall_stable", m_data, hold_data);
                hold_pend = m_valid && !m_ready;
                hold_data = m_data; hold_last = m_last;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) chk(0, "unexpected_out", m_data, 0);
                    else begin
                        e = sb.pop_front();
                        chk(m_data == e.data, "out_data", m_data, e.data);
                        chk(m_last == e.last, "out_last", m_last, e.last);
                        if (chk_lat) chk(cyc + 1 - e.in_cyc == 2, "latency", cyc + 1 - e.in_cyc, 2);
                        if (e.clip) begin prev_clip = 1; last_clip_cyc = cyc + 1; end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_mode) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk(m_valid == 1'b0, "rst_m_valid", m_valid, 0);
        chk(m_data == 24'h0, "rst_m_data", m_data, 0);
        chk(m_last == 1'b0, "rst_m_last", m_last, 0);
        chk(vol_o == 4'd8, "rst_vol", vol_o, 8);
        chk(mute_o == 1'b0, "rst_mute", mute_o, 0);
        chk(clip_o == 1'b0, "rst_clip", clip_o, 0);
        chk(s_ready == 1'b1, "rst_s_ready", s_ready, 1);
        reset_i = 1'b0;
        @(negedge clk);

        // unity gain passthrough with latency
        chk_lat = 1;
        send(24'h100000, 1'b0, 0);
        send(24'hF00000, 1'b1, 0);
        drain();
        chk_lat = 0;

        // mute toggles
        pulse(0, 0, 1);
        chk(mute_o == 1'b1, "mute_on", mute_o, 1);
        send(24'h123456, 1'b0, 0);
        send(24'h123456, 1'b1, 0);
        pulse(0, 0, 1);
        chk(mute_o == 1'b0, "mute_off", mute_o, 0);
        send(24'h123456, 1'b0, 0);
        send(24'h123456, 1'b1, 0);
        drain();

        // volume change during an L sample applies from the next frame
        send(24'h100000, 1'b0, 1);
        send(24'h100000, 1'b1, 0);
        send(24'h100000, 1'b0, 0);
        send(24'h100000, 1'b1, 0);
        drain();
        chk(vol_o == 4'(act_vol), "vol_after_frame", vol_o, act_vol);
        pulse(1, 1, 0);
        chk(vol_o == 4'd9, "vol_up_down_same", vol_o, 9);

        // saturate volume and clip
        for (int i = 0; i < 8; i++) pulse(1, 0, 0);
        chk(vol_o == 4'd15, "vol_sat_max", vol_o, 15);
        send(24'h7FFFFF, 1'b0, 0);
        send(24'h800000, 1'b1, 0);
        drain();
        while (cyc < last_clip_cyc + 4095) @(negedge clk);
        chk(clip_o == 1'b1, "clip_hold_end", clip_o, 1);
        @(negedge clk);
        chk(clip_o == 1'b0, "clip_cleared", clip_o, 0);

        // random backpressure, continuous input
        for (int i = 0; i < 4; i++) pulse(0, 1, 0);
        rand_mode = 1;
        for (int i = 0; i < 200; i++)
            send(24'($urandom), 1'(i % 2), 0);
        drain();

        // full rate with m_ready held high
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            send(24'($urandom), 1'(i % 2), 0);
        chk(cyc - c0 == 16, "throughput", cyc - c0, 16);
        drain();

        // reset with samples in flight
        pulse(1, 0, 0);
        m_ready = 1'b0;
        send(24'h111111, 1'b0, 0);
        send(24'h222222, 1'b1, 0);
        s_valid = 1'b0;
        #1 reset_i = 1'b1;
        #1;
        chk(m_valid == 1'b0, "async_rst_valid", m_valid, 0);
        chk(vol_o == 4'd8, "async_rst_vol", vol_o, 8);
        chk(mute_o == 1'b0, "async_rst_mute", mute_o, 0);
        chk(clip_o == 1'b0, "async_rst_clip", clip_o, 0);
        sb.delete();
        pend_vol = 8; act_vol = 8; pend_mute = 0; act_mute = 0; in_frame = 0;
        @(negedge clk);
        reset_i = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        send(24'h200000, 1'b0, 0);
        send(24'hE00000, 1'b1, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
